bcd_count_display: RTL and testbench

- Consumer end of the debounced trigger interface.
- Takes the 1-cycle increment pulse and per-digit increment mask, and applies them to a DIGITS-wide BCD counter using a digit-serial carry ripple.
- On the refresh pulse, latches the counter into a display register and shifts it out serially to an external shift-register/7-seg driver.
- Sits between the trigger/debounce block and the chip output pins.

---
 rtl/bcd_count_display_pkg.sv | 18 +
 rtl/bcd_count_display_if.sv | 27 ++
 rtl/bcd_serializer.sv | 95 +++++++++
 rtl/bcd_count_display.sv | 123 ++++++++++++
 tb/tb_bcd_count_display.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_count_display_pkg.sv
// Shared encodings and constants for the BCD counter/display block.
package bcd_count_display_pkg;

  typedef enum logic {
    C_IDLE,
    C_ADD
  } cnt_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_LATCH
  } ser_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_count_display_if.sv
// Trigger-side and pin-side signals of the BCD counter/display block.
interface bcd_count_display_if #(
  parameter int DIGITS = 6
) ();

  logic                  inc_clk;
  logic [DIGITS-1:0]     inc_sel;
  logic                  ref_clk;
  logic                  clr;
  logic [4*DIGITS-1:0]   disp_value;
  logic                  busy;
  logic                  overflow;
  logic                  ser_data;
  logic                  ser_clk;
  logic                  ser_latch;

  modport master (
    output inc_clk, inc_sel, ref_clk, clr,
    input  disp_value, busy, overflow, ser_data, ser_clk, ser_latch
  );

  modport slave (
    input  inc_clk, inc_sel, ref_clk, clr,
    output disp_value, busy, overflow, ser_data, ser_clk, ser_latch
  );

endinterface

// File: rtl/bcd_serializer.sv
// Serial shifter for the display word: MSB first, two cycles per bit, then a
// one-cycle storage latch strobe. Requests arriving mid-transfer merge into one.
module bcd_serializer
  import bcd_count_display_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [W-1:0] word,
  output logic         ser_data,
  output logic         ser_clk,
  output logic         ser_latch
);

  localparam int CW = $clog2(W);

  ser_state_e   state_q, state_d;
  logic [W-1:0] word_q, word_d;
  logic [CW-1:0] bit_q, bit_d;
  logic         pend_q, pend_d;
  logic         ser_data_q, ser_data_d;
  logic         ser_clk_q, ser_clk_d;
  logic         ser_latch_q, ser_latch_d;
  logic         start;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_d       = bit_q;
    pend_d      = pend_q;
    ser_data_d  = ser_data_q;
    start       = 1'b0;

    case (state_q)
      S_IDLE:  start = req;
      S_LOW: begin
        state_d = S_HIGH;
        if (req) pend_d = 1'b1;
      end
      S_HIGH: begin
        if (req) pend_d = 1'b1;
        if (bit_q == '0) begin
          state_d = S_LATCH;
        end else begin
          bit_d   = bit_q - 1'b1;
          state_d = S_LOW;
        end
      end
      S_LATCH: begin
        if (req || pend_q) start = 1'b1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Back-to-back transfers reload straight from S_LATCH with the newest word.
    if (start) begin
      word_d  = word;
      bit_d   = CW'(W - 1);
      state_d = S_LOW;
      pend_d  = 1'b0;
    end

    ser_clk_d   = (state_d == S_HIGH);
    ser_latch_d = (state_d == S_LATCH);
    if (state_d == S_LOW) ser_data_d = word_d[bit_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      bit_q       <= '0;
      pend_q      <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_q       <= bit_d;
      pend_q      <= pend_d;
      ser_data_q  <= ser_data_d;
      ser_clk_q   <= ser_clk_d;
      ser_latch_q <= ser_latch_d;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_clk   = ser_clk_q;
  assign ser_latch = ser_latch_q;

endmodule

// File: rtl/bcd_count_display.sv
// DIGITS-wide BCD counter with digit-serial carry ripple, display latch and
// serial output to an external 7-seg shift register.
module bcd_count_display
  import bcd_count_display_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_count_display_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  cnt_state_e                state_q, state_d;
  logic [DIGITS-1:0][3:0]    digits_q, digits_d;
  logic [DIGITS-1:0]         mask_q, mask_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic                      ovf_q, ovf_d;
  logic                      ref_pend_q, ref_pend_d;
  logic [4*DIGITS-1:0]       disp_q, disp_d;
  logic                      shift_req;
  logic [4:0]                sum;
  logic [3:0]                sum_wrap;

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    ref_pend_d = ref_pend_q;
    disp_d     = disp_q;
    shift_req  = 1'b0;

    sum      = {1'b0, digits_q[idx_q]} + {4'd0, mask_q[idx_q]} + {4'd0, carry_q};
    sum_wrap = sum[3:0] - 4'd10;

    // Refresh only latches from idle so a half-rippled value is never shown.
    if (state_q == C_IDLE && (bus.ref_clk || ref_pend_q)) begin
      disp_d     = digits_q;
      shift_req  = 1'b1;
      ref_pend_d = 1'b0;
    end else if (bus.ref_clk) begin
      ref_pend_d = 1'b1;
    end

    if (bus.clr) begin
      digits_d = '0;
      ovf_d    = 1'b0;
      carry_d  = 1'b0;
      state_d  = C_IDLE;
    end else begin
      case (state_q)
        C_IDLE: begin
          if (bus.inc_clk) begin
            mask_d  = bus.inc_sel;
            idx_d   = '0;
            carry_d = 1'b0;
            state_d = C_ADD;
          end
        end
        C_ADD: begin
          if (sum > {1'b0, BCD_MAX}) begin
            digits_d[idx_q] = sum_wrap;
            carry_d         = 1'b1;
          end else begin
            digits_d[idx_q] = sum[3:0];
            carry_d         = 1'b0;
          end
          if (idx_q == IW'(DIGITS - 1)) begin
            ovf_d   = ovf_q | carry_d;
            state_d = C_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= C_IDLE;
      digits_q   <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ref_pend_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      ref_pend_q <= ref_pend_d;
      disp_q     <= disp_d;
    end
  end

  assign bus.disp_value = disp_q;
  assign bus.busy       = (state_q == C_ADD);
  assign bus.overflow   = ovf_q;

  bcd_serializer #(
    .W (4 * DIGITS)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (shift_req),
    .word      (disp_d),
    .ser_data  (bus.ser_data),
    .ser_clk   (bus.ser_clk),
    .ser_latch (bus.ser_latch)
  );

endmodule

// File: tb/tb_bcd_count_display.sv
// Directed bench for bcd_count_display: integer-level reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_bcd_count_display;

  localparam int DIGITS = 6;
  localparam int W      = 4 * DIGITS;
  localparam int MODV   = 1000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_count_display_if #(.DIGITS(DIGITS)) bus ();

  bcd_count_display #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Model: counter as a plain integer; serial output as a queue of
  // per-cycle expectations {check_data, latch, clk, data}.
  int         m_value, m_disp, m_busy;
  logic       m_ovf, m_ovf_pend, m_ref_pend, m_ser_pend;
  logic [3:0] exp_q[$];
  logic       started = 1'b0;

  task automatic load_stream(input logic [W-1:0] w);
    for (int b = W - 1; b >= 0; b--) begin
      exp_q.push_back({1'b1, 1'b0, 1'b0, w[b]});
      exp_q.push_back({1'b1, 1'b0, 1'b1, w[b]});
    end
    exp_q.push_back(4'b0100);
  endtask

  always @(posedge clk) begin
    logic idle, start;
    int   addv, tmp, p;
    if (!rst_n) begin
      m_value = 0; m_disp = 0; m_busy = 0;
      m_ovf = 0; m_ovf_pend = 0; m_ref_pend = 0; m_ser_pend = 0;
      exp_q.delete();
    end else begin
      start = 1'b0;
      idle  = (m_busy == 0);
      if (idle && (bus.ref_clk || m_ref_pend)) begin
        m_disp = m_value; start = 1'b1; m_ref_pend = 1'b0;
      end else if (bus.ref_clk) begin
        m_ref_pend = 1'b1;
      end
      if (bus.clr) begin
        m_value = 0; m_ovf = 0; m_busy = 0; m_ovf_pend = 0;
      end else if (idle) begin
        if (bus.inc_clk) begin
          addv = 0; p = 1;
          for (int i = 0; i < DIGITS; i++) begin
            if (bus.inc_sel[i]) addv += p;
            p = p * 10;
          end
          tmp        = m_value + addv;
          m_ovf_pend = (tmp >= MODV);
          m_value    = tmp % MODV;
          m_busy     = DIGITS;
        end
      end else begin
        m_busy--;
        if (m_busy == 0 && m_ovf_pend) m_ovf = 1'b1;
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        if (start || m_ser_pend) begin
          load_stream(to_bcd(m_disp));
          m_ser_pend = 1'b0;
        end
      end else if (start) begin
        m_ser_pend = 1'b1;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("disp_value", 32'(bus.disp_value), 32'(to_bcd(m_disp)));
      check("busy", 32'(bus.busy), 32'(m_busy != 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      if (exp_q.size() > 0) begin
        check("ser_clk", 32'(bus.ser_clk), 32'(exp_q[0][1]));
        check("ser_latch", 32'(bus.ser_latch), 32'(exp_q[0][2]));
        if (exp_q[0][3]) check("ser_data", 32'(bus.ser_data), 32'(exp_q[0][0]));
      end else begin
        check("ser_clk_idle", 32'(bus.ser_clk), 32'd0);
        check("ser_latch_idle", 32'(bus.ser_latch), 32'd0);
      end
    end
  end

  task automatic inc(input logic [DIGITS-1:0] sel);
    @(negedge clk); bus.inc_clk = 1'b1; bus.inc_sel = sel;
    @(negedge clk); bus.inc_clk = 1'b0; bus.inc_sel = '0;
    repeat (7) @(negedge clk);
  endtask

  task automatic ref_pulse();
    @(negedge clk); bus.ref_clk = 1'b1;
    @(negedge clk); bus.ref_clk = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk); bus.clr = 1'b1;
    @(negedge clk); bus.clr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] bits;
    int   lat_cyc, busy_cnt, n_lat, lat1, lat2;
    logic prev;

    bus.inc_clk = 1'b0; bus.inc_sel = '0; bus.ref_clk = 1'b0; bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_disp", 32'(bus.disp_value), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_ser_data", 32'(bus.ser_data), 32'h0);
    rst_n = 1'b1;

    // First increment: busy must last exactly DIGITS cycles.
    @(negedge clk); bus.inc_clk = 1'b1; bus.inc_sel = 6'b000001;
    @(negedge clk); bus.inc_clk = 1'b0; bus.inc_sel = '0;
    busy_cnt = 32'(bus.busy);
    repeat (11) begin @(negedge clk); busy_cnt += 32'(bus.busy); end
    check("busy_cycles", 32'(busy_cnt), 32'd6);
    repeat (4) inc(6'b000001);

    ref_pulse();
    check("disp_5", 32'(bus.disp_value), 32'h000005);
    bits = '0; lat_cyc = -1; prev = 1'b0;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      if (bus.ser_clk && !prev) bits = {bits[W-2:0], bus.ser_data};
      prev = bus.ser_clk;
      if (bus.ser_latch) begin lat_cyc = c; break; end
    end
    check("ser_stream", 32'(bits), 32'h000005);
    check("ser_latch_cycle", 32'(lat_cyc), 32'd49);
    repeat (3) @(negedge clk);

    // Coincident ref and inc: latch the pre-increment value.
    @(negedge clk); bus.inc_clk = 1'b1; bus.inc_sel = 6'b000001; bus.ref_clk = 1'b1;
    @(negedge clk); bus.inc_clk = 1'b0; bus.inc_sel = '0; bus.ref_clk = 1'b0;
    check("coincident_pre", 32'(bus.disp_value), 32'h000005);
    repeat (20) @(negedge clk);

    // Reset in the middle of that transfer; no latch strobe may follow.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_disp", 32'(bus.disp_value), 32'h0);
    check("midrst_ser_data", 32'(bus.ser_data), 32'h0);
    check("midrst_ser_clk", 32'(bus.ser_clk), 32'h0);
    rst_n = 1'b1;
    n_lat = 0;
    repeat (60) begin @(negedge clk); if (bus.ser_latch) n_lat++; end
    check("midrst_no_latch", 32'(n_lat), 32'd0);

    // 099999 + 1 -> 100000
    repeat (9) inc(6'b011111);
    inc(6'b000001);
    ref_pulse();
    check("disp_100000", 32'(bus.disp_value), 32'h100000);
    check("ovf_100000", 32'(bus.overflow), 32'h0);
    repeat (55) @(negedge clk);

    // 999999 + 1 -> 000000 with overflow, then clr.
    clr_pulse();
    repeat (9) inc(6'b111111);
    inc(6'b000001);
    check("ovf_set", 32'(bus.overflow), 32'h1);
    ref_pulse();
    check("disp_wrap", 32'(bus.disp_value), 32'h000000);
    clr_pulse();
    check("ovf_clr", 32'(bus.overflow), 32'h0);
    repeat (55) @(negedge clk);

    // 000009 + mask 000011 -> 000020
    repeat (9) inc(6'b000001);
    inc(6'b000011);
    ref_pulse();
    check("disp_20", 32'(bus.disp_value), 32'h000020);
    repeat (55) @(negedge clk);

    // ref while busy: display waits for the ripple to finish.
    @(negedge clk); bus.inc_clk = 1'b1; bus.inc_sel = 6'b000001;
    @(negedge clk); bus.inc_clk = 1'b0; bus.inc_sel = '0;
    @(negedge clk); bus.ref_clk = 1'b1;
    @(negedge clk); bus.ref_clk = 1'b0;
    check("busy_ref_stale", 32'(bus.disp_value), 32'h000020);
    repeat (8) @(negedge clk);
    check("busy_ref_new", 32'(bus.disp_value), 32'h000021);
    repeat (55) @(negedge clk);

    // Second ref mid-transfer: two latch strobes exactly one transfer apart.
    ref_pulse();
    repeat (10) @(negedge clk);
    ref_pulse();
    n_lat = 0; lat1 = 0; lat2 = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (bus.ser_latch) begin
        n_lat++;
        if (n_lat == 1) lat1 = c; else lat2 = c;
      end
    end
    check("double_ref_latches", 32'(n_lat), 32'd2);
    check("double_ref_spacing", 32'(lat2 - lat1), 32'd49);

    // clr aborts a ripple in progress and wins over inc.
    @(negedge clk); bus.inc_clk = 1'b1; bus.inc_sel = 6'b111111;
    @(negedge clk); bus.inc_clk = 1'b0; bus.inc_sel = '0;
    @(negedge clk); bus.clr = 1'b1; bus.inc_clk = 1'b1; bus.inc_sel = 6'b000001;
    @(negedge clk); bus.clr = 1'b0; bus.inc_clk = 1'b0; bus.inc_sel = '0;
    repeat (8) @(negedge clk);
    ref_pulse();
    check("clr_abort", 32'(bus.disp_value), 32'h000000);
    repeat (55) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
